// File: rtl/jtag_dbg_pkg.sv
// Shared constants and width helpers for the virtual-JTAG command bridge.
package jtag_dbg_pkg;

   localparam int DEF_IR_WIDTH    = 2;
   localparam int DEF_DR_WIDTH    = 38;
   localparam int DEF_SYNC_STAGES = 2;
   localparam int DEF_DEPTH       = 2;
   localparam int DEF_ACT_BIT     = 34;

   // Number of instruction channels addressable by an IR of the given width.
   function automatic int n_ch(input int ir_width);
      return 1 << ir_width;
   endfunction

   // Width needed to hold an occupancy of 0..depth.
   function automatic int level_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Pointer width; a single-entry FIFO still needs a one-bit pointer.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/jtag_dbg_sync.sv
// Multi-flop level synchroniser for a single control bit from the tck domain.
module jtag_dbg_sync
   import jtag_dbg_pkg::*;
#(
   parameter int STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   // Shift the asynchronous level through the flop chain.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         chain <= '0;
      end else begin
         chain <= {chain[STAGES-2:0], d};
      end
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/jtag_dbg_cmd_sysclk.sv
// Moves update-DR snapshots from the tck domain into a small system-clock FIFO
// and decodes the head command into per-channel accept pulses.
module jtag_dbg_cmd_sysclk
   import jtag_dbg_pkg::*;
#(
   parameter int IR_WIDTH    = DEF_IR_WIDTH,
   parameter int DR_WIDTH    = DEF_DR_WIDTH,
   parameter int SYNC_STAGES = DEF_SYNC_STAGES,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int ACT_BIT     = DEF_ACT_BIT
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [IR_WIDTH-1:0]          ir_in,
   input  logic [DR_WIDTH-1:0]          sr,
   input  logic                         vs_udr,
   input  logic                         vs_uir,
   input  logic                         cmd_ready,
   input  logic                         overrun_clr,
   output logic                         cmd_valid,
   output logic [DR_WIDTH-1:0]          jdo,
   output logic [IR_WIDTH-1:0]          cmd_ir,
   output logic [n_ch(IR_WIDTH)-1:0]    take_action,
   output logic [n_ch(IR_WIDTH)-1:0]    take_no_action,
   output logic                         ir_update,
   output logic                         overrun,
   output logic [level_w(DEPTH)-1:0]    fifo_level
);

   localparam int N_CH = n_ch(IR_WIDTH);
   localparam int LW   = level_w(DEPTH);
   localparam int PW   = ptr_w(DEPTH);
   localparam int EW   = IR_WIDTH + DR_WIDTH;

   logic          udr_sync, uir_sync;
   logic          udr_prev, uir_prev;
   logic          udr_rise, uir_rise;
   logic          full, pop, push_ok, drop;
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [EW-1:0] mem [DEPTH];

   jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_udr (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (vs_udr),
      .q       (udr_sync)
   );

   jtag_dbg_sync #(.STAGES(SYNC_STAGES)) u_sync_uir (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (vs_uir),
      .q       (uir_sync)
   );

   // Delayed copies of the synchronised levels for rising-edge detection.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         udr_prev <= 1'b0;
         uir_prev <= 1'b0;
      end else begin
         udr_prev <= udr_sync;
         uir_prev <= uir_sync;
      end
   end

   assign udr_rise = udr_sync & ~udr_prev;
   assign uir_rise = uir_sync & ~uir_prev;

   // Register the update-IR edge into a clean one-cycle pulse.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         ir_update <= 1'b0;
      end else begin
         ir_update <= uir_rise;
      end
   end

   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign cmd_valid = (fifo_level != '0);
   assign full      = (fifo_level == LW'(DEPTH));
   assign pop       = cmd_valid & cmd_ready;
   assign push_ok   = udr_rise & (~full | pop);
   assign drop      = udr_rise & full & ~pop;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Command storage; contents need no reset because the pointers gate them.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem[wr_ptr] <= {ir_in, sr};
      end
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= next_ptr(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= next_ptr(rd_ptr);
         end
         case ({push_ok, pop})
            2'b10:   fifo_level <= fifo_level + LW'(1);
            2'b01:   fifo_level <= fifo_level - LW'(1);
            default: fifo_level <= fifo_level;
         endcase
      end
   end

   // Sticky overrun; a fresh drop outranks a same-cycle clear.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (overrun_clr) begin
         overrun <= 1'b0;
      end
   end

   assign {cmd_ir, jdo} = mem[rd_ptr];

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_decode
         assign take_action[gi]    = pop & (cmd_ir == IR_WIDTH'(gi)) &  jdo[ACT_BIT];
         assign take_no_action[gi] = pop & (cmd_ir == IR_WIDTH'(gi)) & ~jdo[ACT_BIT];
      end
   endgenerate

endmodule

// File: doc/jtag_dbg_cmd_sysclk.md
JTAG_DBG_CMD_SYSCLK -- requirements
Module: jtag_dbg_cmd_sysclk

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 2: virtual-JTAG instruction width; channel count N_CH = 2**IR_WIDTH.
REQ-002 SHALL have parameter DR_WIDTH, default 38: captured data-register width.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, legal 2..4: synchroniser depth for vs_udr and vs_uir.
REQ-004 SHALL have parameter DEPTH, default 2, power of two, at least 1: command FIFO depth.
REQ-005 SHALL have parameter ACT_BIT, default 34, range 0..DR_WIDTH-1: captured bit that selects action or no-action.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 clk  in  1  system clock; all state updates on its rising edge.
REQ-008 reset_n  in  1  synchronous active-low reset.
REQ-009 ir_in  in  IR_WIDTH  instruction from the tck domain; stable while vs_udr is high.
REQ-010 sr  in  DR_WIDTH  shift-register snapshot from the tck domain; stable while vs_udr is high.
REQ-011 vs_udr  in  1  update-DR level from the tck domain; asynchronous to clk.
REQ-012 vs_uir  in  1  update-IR level from the tck domain; asynchronous to clk.
REQ-013 cmd_ready  in  1  consumer accepts the head command.
REQ-014 overrun_clr  in  1  clears the overrun flag.
REQ-015 cmd_valid  out  1  FIFO is non-empty.
REQ-016 jdo  out  DR_WIDTH  captured data at the FIFO head.
REQ-017 cmd_ir  out  IR_WIDTH  captured instruction at the FIFO head.
REQ-018 take_action  out  N_CH  one-hot accept pulse when jdo[ACT_BIT] is 1.
REQ-019 take_no_action  out  N_CH  one-hot accept pulse when jdo[ACT_BIT] is 0.
REQ-020 ir_update  out  1  single-cycle pulse on each update-IR.
REQ-021 overrun  out  1  sticky flag: a command was dropped.
REQ-022 fifo_level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-023 SHALL pass vs_udr and vs_uir each through SYNC_STAGES flops, then rising-edge detect against one further registered copy.
REQ-024 On a synchronised vs_udr rising edge, SHALL push {ir_in, sr} into the FIFO on that same clock edge.
REQ-025 Latency: with the FIFO empty, cmd_valid SHALL be high after clock edge SYNC_STAGES+1, counting as edge 1 the first edge that samples vs_udr high (edge 3 at the default).
REQ-026 jdo and cmd_ir SHALL show the FIFO head; their values are don't-care when cmd_valid is 0.
REQ-027 A pop SHALL occur when cmd_valid and cmd_ready are both 1, with the head advancing on that edge.
REQ-028 take_action[i] SHALL equal cmd_valid & cmd_ready & (cmd_ir==i) & jdo[ACT_BIT]; the output is combinational and at most one bit of the vector is high.
REQ-029 take_no_action[i] SHALL be defined as in REQ-028 but with ~jdo[ACT_BIT].
REQ-030 A push while full and with no pop SHALL drop the new command, leave the FIFO contents unchanged, and set overrun on that edge.
REQ-031 A simultaneous push and pop while full SHALL accept both, leaving the level unchanged and overrun unaffected.
REQ-032 A simultaneous push and pop while empty SHALL be impossible, because a pop requires cmd_valid.
REQ-033 overrun_clr SHALL clear overrun on the next edge; a same-cycle new overrun event SHALL win, leaving the flag set.
REQ-034 A synchronised vs_uir rising edge SHALL produce a one-cycle ir_update pulse with no effect on the FIFO.
REQ-035 Pointers SHALL wrap modulo DEPTH; fifo_level SHALL range 0..DEPTH.
REQ-036 A vs_udr level held high SHALL yield exactly one push until it falls and rises again.

Reset
REQ-037 While reset_n is 0, SHALL clear synchronisers, edge registers, pointers, fifo_level and overrun to 0.
REQ-038 After reset, cmd_valid, take_action, take_no_action, ir_update and overrun SHALL be 0; jdo and cmd_ir are don't-care.
REQ-039 Reset mid-transfer SHALL discard all queued commands; a vs_udr held high through reset SHALL produce one push after release.

Structure
REQ-040 Package jtag_dbg_pkg SHALL hold the default parameter constants and the N_CH and level-width derivations.
REQ-041 SHALL instantiate sub-module jtag_dbg_sync (parametrised SYNC_STAGES, 1-bit) twice; the FIFO is inline.

Verification
REQ-042 Default parameters, sr=38'h4_0000_0001 (bit 34 set), ir_in=2, pulse vs_udr, cmd_ready=1 -> cmd_valid at edge 3, jdo=38'h4_0000_0001, take_action=4'b0100 for 1 cycle.
REQ-043 Same sequence with bit 34 clear and ir_in=0 -> take_no_action=4'b0001, take_action=0.
REQ-044 cmd_ready=0, three vs_udr pulses, DEPTH=2 -> fifo_level=2, overrun=1, both heads are the first two values; then overrun_clr -> overrun=0.
REQ-045 FIFO full, pop and push on the same edge -> fifo_level stays 2, overrun stays 0, order preserved.
REQ-046 vs_uir pulse -> single ir_update pulse at edge 3, fifo_level unchanged.
REQ-047 Two entries queued, reset_n=0 for 1 cycle -> cmd_valid=0, fifo_level=0, overrun=0.
